// File: rtl/pio_cond_pkg.sv
// Shared constants and helpers for the PIO input-conditioning blocks.
package pio_cond_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_WIDTH           = 8;

    // Counter width for a count range of 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: two-flop synchronizer, integrating debounce counter,
// debounced level flop and registered rise/fall pulses.
module pio_debounce_bit
    import pio_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic next_rise,
    output logic next_fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt_p2;
    logic             differ;
    logic             expire;

    // Synchronized level has disagreed with clean for the full window.
    assign differ    = (sync_p1 != clean);
    assign expire    = differ && (cnt_p2 == CNT_LAST);
    assign next_rise = expire && sync_p1;
    assign next_fall = expire && !sync_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            cnt_p2  <= '0;
            clean   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            // stage p0/p1: metastability synchronizer, nothing in between
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // stage p2: integrate disagreement, cleared on agreement or update
            if (!differ) begin
                cnt_p2 <= '0;
            end else if (expire) begin
                clean  <= sync_p1;
                cnt_p2 <= '0;
            end else begin
                cnt_p2 <= cnt_p2 + CNT_W'(1);
            end
            rise <= next_rise;
            fall <= next_fall;
        end
    end

endmodule

// File: rtl/pio_input_debouncer.sv
// Debounces WIDTH asynchronous board inputs for the PIO in_port and produces
// per-bit edge pulses plus an aggregate change strobe.
module pio_input_debouncer
    import pio_cond_pkg::*;
#(
    parameter int WIDTH           = DEFAULT_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_strobe
);

    logic [WIDTH-1:0] next_rise;
    logic [WIDTH-1:0] next_fall;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .reset    (reset),
            .raw      (raw_in[g]),
            .clean    (clean_out[g]),
            .rise     (rise_pulse[g]),
            .fall     (fall_pulse[g]),
            .next_rise(next_rise[g]),
            .next_fall(next_fall[g])
        );
    end

    // Registered from the same next-cycle conditions so it aligns with the pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            change_strobe <= 1'b0;
        end else begin
            change_strobe <= |(next_rise | next_fall);
        end
    end

endmodule

// File: tb/tb_pio_input_debouncer.sv
// Scoreboard bench for pio_input_debouncer: DEBOUNCE_CYCLES=4 and =1 builds
// share one stimulus stream and a window-based reference model.
module tb_pio_input_debouncer;

    typedef struct packed {
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       strobe;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] raw = 8'hFF;

    logic [7:0] clean4, rise4, fall4;
    logic       strobe4;
    logic [7:0] clean1, rise1, fall1;
    logic       strobe1;

    int compared   = 0;
    int mismatched = 0;
    int edge_n     = 0;

    obs_t       q4[$];
    obs_t       q1[$];
    logic [7:0] samp[16];
    logic [7:0] mclean[2];
    int         last_upd[2][8];

    always #5 clk = ~clk;

    pio_input_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset), .raw_in(raw),
        .clean_out(clean4), .rise_pulse(rise4), .fall_pulse(fall4),
        .change_strobe(strobe4)
    );

    pio_input_debouncer #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .raw_in(raw),
        .clean_out(clean1), .rise_pulse(rise1), .fall_pulse(fall1),
        .change_strobe(strobe1)
    );

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    // A bit updates at edge n when its synchronized sample (raw taken two
    // edges earlier) differed from the debounced level on each of the last
    // dc edges, all of them after the previous update or reset.
    function automatic obs_t model_step(input int inst, input int dc, input int n, input logic rst);
        obs_t o;
        logic ok;
        o = '0;
        if (rst) begin
            mclean[inst] = 8'h00;
            for (int b = 0; b < 8; b++) last_upd[inst][b] = n;
        end else begin
            for (int b = 0; b < 8; b++) begin
                ok = 1'b1;
                for (int j = n - dc + 1; j <= n; j++) begin
                    if (j <= last_upd[inst][b] || samp[(j - 2) & 15][b] == mclean[inst][b])
                        ok = 1'b0;
                end
                if (ok) begin
                    mclean[inst][b] = ~mclean[inst][b];
                    if (mclean[inst][b]) o.rise[b] = 1'b1;
                    else                 o.fall[b] = 1'b1;
                    last_upd[inst][b] = n;
                end
            end
        end
        o.clean  = mclean[inst];
        o.strobe = |(o.rise | o.fall);
        return o;
    endfunction

    // Reference model: runs on each active edge, queues the expected outputs.
    initial begin
        for (int i = 0; i < 16; i++) samp[i] = 8'h00;
        forever begin
            @(posedge clk);
            edge_n++;
            q4.push_back(model_step(0, 4, edge_n, reset));
            q1.push_back(model_step(1, 1, edge_n, reset));
            samp[edge_n & 15] = reset ? 8'h00 : raw;
            if (reset) samp[(edge_n - 1) & 15] = 8'h00;
        end
    end

    // Monitor: outputs are registers valid every cycle; compare mid-cycle.
    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            if (edge_n > 0) begin
                if (q4.size() == 0 || q1.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL scoreboard_empty: got %0d/%0d entries expected >0", q4.size(), q1.size());
                end else begin
                    e = q4.pop_front();
                    chk("d4_clean", clean4, e.clean);
                    chk("d4_rise", rise4, e.rise);
                    chk("d4_fall", fall4, e.fall);
                    chk("d4_strobe", {7'b0, strobe4}, {7'b0, e.strobe});
                    e = q1.pop_front();
                    chk("d1_clean", clean1, e.clean);
                    chk("d1_rise", rise1, e.rise);
                    chk("d1_fall", fall1, e.fall);
                    chk("d1_strobe", {7'b0, strobe1}, {7'b0, e.strobe});
                end
            end
        end
    end

    task automatic hold(input logic [7:0] v, input int cycles);
        raw = v;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Edge 0 is the first edge with reset low; FF appears at edge 5.
        for (int e = 0; e <= 6; e++) begin
            @(negedge clk);
            if (e < 5) begin
                chk("release_clean_low", clean4, 8'h00);
            end else if (e == 5) begin
                chk("release_clean", clean4, 8'hFF);
                chk("release_rise", rise4, 8'hFF);
                chk("release_strobe", {7'b0, strobe4}, 8'h01);
            end else begin
                chk("release_rise_once", rise4, 8'h00);
                chk("release_strobe_once", {7'b0, strobe4}, 8'h00);
            end
        end
        hold(8'h00, 12);
        hold(8'h01, 10);
        hold(8'h09, 3);
        hold(8'h01, 10);
        hold(8'h09, 5);
        hold(8'h01, 10);
        hold(8'h43, 10);
        // Reset lands while bit 2 is mid-count.
        hold(8'h47, 4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hold(8'h47, 10);
        hold(8'h00, 10);
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] v;
            v = raw;
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) v[b] = ~v[b];
            raw   = v;
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        hold(raw, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
